bitstuff_transmitter: RTL and testbench
=======================================

// Module: bitstuff_transmitter
// PURPOSE
//  Serial packet transmitter for the SIE link layer. It emits a SYNC field, then a
//  bit-stuffed data word, then an EOP, all NRZI-encoded on one output line.
//  It sits between the SIE packet logic (parallel word in) and the line driver
//  (one bit per clk out). opcode exports the current line phase for monitors and debug.
// PARAMETERS
//  DATA_W       16  width of data_in; data bits per packet
//  SYNC_W       8   width of sync_data; SYNC bits per packet
//  STUFF_LIMIT  6   run of consecutive 1s after which a 0 is inserted
//  EOP_LEN      2   EOP cycles, driven as line level 0
// PORTS
//  clk              in   1       single clock; one line bit per rising edge
//  rst              in   1       synchronous, active-high reset
//  SIE              in   1       transmit request, sampled only in IDLE
//  STUFF_OPER_tx    in   1       1 = bit stuffing enabled; latched at packet start
//  sync_data        in   SYNC_W  SYNC pattern; latched at packet start
//  data_in          in   DATA_W  payload word; latched at packet start
//  SYNC_pattern     out  1       1 while a SYNC bit is on encoded_dataout
//  encoded_dataout  out  1       NRZI line output, registered
//  opcode           out  4       phase of the bit now on the line, registered
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state IDLE; encoded_dataout=1; SYNC_pattern=0;
//    opcode=4'h0; NRZI level=1; all counters=0. Reset applies mid-packet; the packet is aborted.
//  - opcode codes: 0 IDLE, 1 SYNC, 2 DATA, 3 STUFF (stuffed 0 on line), 4 EOP.
//    Codes 5-F are unused. Outputs update together, so opcode always matches encoded_dataout.
//  - Edge E0 (IDLE, SIE=1): latch sync_data, data_in and STUFF_OPER_tx; go to SYNC.
//    The line stays 1 on this edge.
//  - SYNC phase, edges E1..E8: emit sync bit i, LSB first. SYNC_pattern=1 and opcode=1.
//    SYNC bits are never stuffed and do not count toward the ones-run.
//  - DATA phase: one bit per edge, LSB first; opcode=2. The ones-run counter starts at 0.
//    A 1 increments the counter; a 0 clears it.
//  - Stuffing: if enabled and the counter reaches STUFF_LIMIT after a data 1, the next
//    edge emits a 0 (opcode=3) and clears the counter. The data index does not advance.
//    A stuff bit is still inserted after a run that ends on the last data bit.
//  - With stuffing disabled, DATA lasts exactly DATA_W cycles.
//  - NRZI: a bit value of 0 toggles the line level; a bit value of 1 holds it.
//    This applies to SYNC, DATA and STUFF bits.
//  - EOP: EOP_LEN edges drive encoded_dataout=0 (opcode=4).
//    The next edge drives 1, resets the NRZI level to 1, and returns to IDLE (opcode=0).
//  - Back-to-back packets: if SIE=1 in IDLE, the next packet starts on the following edge.
//  - SIE deassert mid-packet is ignored; the packet completes.
//  - Input changes mid-packet have no effect, because the values are latched at E0.
//  - Packet length = 1 + SYNC_W + DATA_W + n_stuff + EOP_LEN + 1 edges, from E0 to IDLE.
// STRUCTURE
//  - Shared package tx_pkg holds the state enum {IDLE,SYNC,DATA,STUFF,EOP}, the opcode
//    constants, and the default SYNC_W, DATA_W, STUFF_LIMIT and EOP_LEN.
//  - One sub-module, nrzi_encoder: clk, rst, bit_valid, bit_in, force_se0, force_idle
//    -> line. It holds the level register.
//  - Top level holds the FSM, the shift registers, the bit/ones counters and the stuff logic.
// TESTING
//  1. Reset with rst=1 for 1 edge -> encoded_dataout=1, SYNC_pattern=0, opcode=0,
//     and these hold while SIE=0.
//  2. sync_data=8'h7E, SIE=1 -> E1..E8 line = 0,0,0,0,0,0,0,1; SYNC_pattern=1 on
//     exactly those 8 cycles; opcode=1.
//  3. data_in=16'hBCF2, stuffing on -> no stuff bits (max run 4). DATA lasts 16 cycles;
//     bits LSB first are 0100111100111101. Check the NRZI line against a reference model.
//  4. data_in=16'hFFFF, stuffing on -> DATA+STUFF = 18 cycles; opcode=3 at positions 7 and 14.
//     Line holds through each 1-run and toggles on each stuff bit.
//  5. data_in=16'hFFFF, STUFF_OPER_tx=0 -> 16 data cycles, no opcode=3, then 2 EOP cycles
//     with line 0, then line 1 and IDLE.
//  6. Assert rst mid-DATA -> next edge IDLE/line 1; SIE held 1 -> packets repeat
//     back-to-back, each with E0 line=1.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared types and constants for the bit-stuffing serial transmitter:
// FSM state encoding, line-phase opcodes and default packet geometry.
package tx_pkg;

  localparam int DEF_SYNC_W      = 8;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_STUFF_LIMIT = 6;
  localparam int DEF_EOP_LEN     = 2;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    EOP
  } tx_state_e;

  localparam logic [3:0] OP_IDLE  = 4'h0;
  localparam logic [3:0] OP_SYNC  = 4'h1;
  localparam logic [3:0] OP_DATA  = 4'h2;
  localparam logic [3:0] OP_STUFF = 4'h3;
  localparam logic [3:0] OP_EOP   = 4'h4;

endpackage

// File: rtl/nrzi_encoder.sv
// NRZI line encoder: a 0 bit toggles the line level, a 1 bit holds it.
// Also forces the line to 0 for EOP or back to idle level 1.
module nrzi_encoder (
  input  logic clk,
  input  logic rst,
  input  logic bit_valid,
  input  logic bit_in,
  input  logic force_se0,
  input  logic force_idle,
  output logic line
);

  logic level_q;
  logic line_q;
  logic level_d;

  assign level_d = bit_in ? level_q : ~level_q;

  // The level is kept separately from the line so that EOP can drive 0
  // without disturbing it; returning to idle restores it to 1.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || force_idle) begin
      level_q <= 1'b1;
      line_q  <= 1'b1;
    end else if (force_se0) begin
      line_q  <= 1'b0;
    end else if (bit_valid) begin
      level_q <= level_d;
      line_q  <= level_d;
    end else begin
      line_q  <= level_q;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/bitstuff_transmitter.sv
// Packet transmitter: SYNC field, bit-stuffed LSB-first data word, then EOP,
// all NRZI-encoded onto one line with a registered phase opcode.
module bitstuff_transmitter
  import tx_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_W      = DEF_SYNC_W,
  parameter int STUFF_LIMIT = DEF_STUFF_LIMIT,
  parameter int EOP_LEN     = DEF_EOP_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SIE,
  input  logic              STUFF_OPER_tx,
  input  logic [SYNC_W-1:0] sync_data,
  input  logic [DATA_W-1:0] data_in,
  output logic              SYNC_pattern,
  output logic              encoded_dataout,
  output logic [3:0]        opcode
);

  localparam int CNT_W  = $clog2(DATA_W + SYNC_W + EOP_LEN + 1);
  localparam int ONES_W = $clog2(STUFF_LIMIT + 1);

  tx_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ONES_W-1:0] ones_q;
  logic [ONES_W-1:0] ones_d;
  logic [SYNC_W-1:0] sync_q;
  logic [DATA_W-1:0] data_q;
  logic              stuff_en_q;
  logic [3:0]        opcode_q;
  logic              sync_pattern_q;

  logic bit_valid;
  logic bit_in;
  logic force_se0;
  logic force_idle;
  logic stuff_req;
  logic eop_done;

  assign ones_d    = data_q[0] ? ones_q + 1'b1 : '0;
  assign stuff_req = stuff_en_q && data_q[0] && (ones_d == ONES_W'(STUFF_LIMIT));
  assign eop_done  = (cnt_q == CNT_W'(EOP_LEN));

  // Encoder controls are decoded from the current state, so the encoder's
  // registered line lands on the same edge as the registered opcode.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves one unassigned and infers a latch.
  always_comb begin
    bit_valid  = 1'b0;
    bit_in     = 1'b1;
    force_se0  = 1'b0;
    force_idle = 1'b0;
    case (state_q)
      IDLE:  force_idle = 1'b1;
      SYNC:  begin bit_valid = 1'b1; bit_in = sync_q[0]; end
      DATA:  begin bit_valid = 1'b1; bit_in = data_q[0]; end
      STUFF: begin bit_valid = 1'b1; bit_in = 1'b0;      end
      EOP:   if (eop_done) force_idle = 1'b1; else force_se0 = 1'b1;
      default: force_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      ones_q         <= '0;
      sync_q         <= '0;
      data_q         <= '0;
      stuff_en_q     <= 1'b0;
      opcode_q       <= OP_IDLE;
      sync_pattern_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          opcode_q       <= OP_IDLE;
          sync_pattern_q <= 1'b0;
          cnt_q          <= '0;
          ones_q         <= '0;
          if (SIE) begin
            sync_q     <= sync_data;
            data_q     <= data_in;
            stuff_en_q <= STUFF_OPER_tx;
            state_q    <= SYNC;
          end
        end
        SYNC: begin
          opcode_q       <= OP_SYNC;
          sync_pattern_q <= 1'b1;
          sync_q         <= sync_q >> 1;
          if (cnt_q == CNT_W'(SYNC_W - 1)) begin
            cnt_q   <= '0;
            ones_q  <= '0;
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          opcode_q       <= OP_DATA;
          sync_pattern_q <= 1'b0;
          data_q         <= data_q >> 1;
          ones_q         <= ones_d;
          // cnt_q counts consumed data bits; STUFF uses it to spot the last one.
          if (stuff_req) begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= STUFF;
          end else if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_q   <= '0;
            state_q <= EOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STUFF: begin
          opcode_q       <= OP_STUFF;
          sync_pattern_q <= 1'b0;
          ones_q         <= '0;
          if (cnt_q == CNT_W'(DATA_W)) begin
            cnt_q   <= '0;
            state_q <= EOP;
          end else begin
            state_q <= DATA;
          end
        end
        EOP: begin
          sync_pattern_q <= 1'b0;
          if (eop_done) begin
            opcode_q <= OP_IDLE;
            cnt_q    <= '0;
            state_q  <= IDLE;
          end else begin
            opcode_q <= OP_EOP;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        default: begin
          opcode_q       <= OP_IDLE;
          sync_pattern_q <= 1'b0;
          state_q        <= IDLE;
        end
      endcase
    end
  end

  nrzi_encoder u_nrzi (
    .clk        (clk),
    .rst        (rst),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .force_se0  (force_se0),
    .force_idle (force_idle),
    .line       (encoded_dataout)
  );

  assign opcode       = opcode_q;
  assign SYNC_pattern = sync_pattern_q;

endmodule

// File: tb/tb_bitstuff_transmitter.sv
// Self-checking bench: a packet-level reference model builds the expected line
// sequence per packet; directed packets pin that model with literal values.
module tb_bitstuff_transmitter;
  import tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SIE = 1'b0;
  logic        STUFF_OPER_tx = 1'b0;
  logic [7:0]  sync_data = '0;
  logic [15:0] data_in = '0;
  logic        SYNC_pattern;
  logic        encoded_dataout;
  logic [3:0]  opcode;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bitstuff_transmitter dut (
    .clk             (clk),
    .rst             (rst),
    .SIE             (SIE),
    .STUFF_OPER_tx   (STUFF_OPER_tx),
    .sync_data       (sync_data),
    .data_in         (data_in),
    .SYNC_pattern    (SYNC_pattern),
    .encoded_dataout (encoded_dataout),
    .opcode          (opcode)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       line;
    logic [3:0] op;
    logic       sp;
  } exp_t;

  localparam exp_t IDLE_EXP = '{line: 1'b1, op: OP_IDLE, sp: 1'b0};

  exp_t exp_q[$];
  exp_t exp_cur = IDLE_EXP;
  bit   chk_en = 1'b0;

  // Whole packet from E0 to the return-to-idle edge, one entry per edge.
  function automatic void build_pkt(input logic [7:0] s, input logic [15:0] d, input logic st);
    exp_t raw[$];
    logic lvl = 1'b1;
    int   run = 0;
    for (int i = 0; i < DEF_SYNC_W; i++)
      raw.push_back('{line: s[i], op: OP_SYNC, sp: 1'b1});
    for (int i = 0; i < DEF_DATA_W; i++) begin
      raw.push_back('{line: d[i], op: OP_DATA, sp: 1'b0});
      run = d[i] ? run + 1 : 0;
      if (st && run == DEF_STUFF_LIMIT) begin
        raw.push_back('{line: 1'b0, op: OP_STUFF, sp: 1'b0});
        run = 0;
      end
    end
    exp_q.push_back(IDLE_EXP);
    foreach (raw[i]) begin
      if (!raw[i].line) lvl = ~lvl;
      exp_q.push_back('{line: lvl, op: raw[i].op, sp: raw[i].sp});
    end
    repeat (DEF_EOP_LEN) exp_q.push_back('{line: 1'b0, op: OP_EOP, sp: 1'b0});
    exp_q.push_back(IDLE_EXP);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_cur <= IDLE_EXP;
      chk_en  <= 1'b1;
    end else begin
      if (exp_q.size() == 0 && SIE) build_pkt(sync_data, data_in, STUFF_OPER_tx);
      if (exp_q.size() == 0) exp_cur <= IDLE_EXP;
      else                   exp_cur <= exp_q.pop_front();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_line",   32'(encoded_dataout), 32'(exp_cur.line));
      check("model_opcode", 32'(opcode),          32'(exp_cur.op));
      check("model_sync",   32'(SYNC_pattern),    32'(exp_cur.sp));
    end
  end

  // ---------------- directed packet capture ----------------
  logic       cap_line[0:99];
  logic [3:0] cap_op[0:99];
  logic       cap_sp[0:99];
  int         cap_n;

  // Called at a negedge; index 0 is the E0 edge. Inputs are scrambled after
  // E0 to show they were latched.
  task automatic run_pkt(input logic [7:0] s, input logic [15:0] d, input logic st);
    sync_data = s; data_in = d; STUFF_OPER_tx = st; SIE = 1'b1;
    cap_n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) begin
        SIE = 1'b0; sync_data = ~s; data_in = ~d; STUFF_OPER_tx = ~st;
      end
      cap_line[k] = encoded_dataout;
      cap_op[k]   = opcode;
      cap_sp[k]   = SYNC_pattern;
      if (k > 0 && opcode == OP_IDLE) begin
        cap_n = k + 1;
        break;
      end
    end
    if (cap_n == 0) check("pkt_timeout", 32'd1, 32'd0);
  endtask

  function automatic int count_op(input logic [3:0] op);
    int c = 0;
    for (int i = 0; i < cap_n; i++) if (cap_op[i] == op) c++;
    return c;
  endfunction

  initial begin
    logic [7:0]  v8;
    logic [15:0] v16;
    int          c;
    bit          seen;

    // Reset and idle hold
    @(negedge clk);
    check("rst_line", 32'(encoded_dataout), 32'd1);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_sync", 32'(SYNC_pattern), 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_line", 32'(encoded_dataout), 32'd1);
      check("idle_opcode", 32'(opcode), 32'd0);
    end

    // SYNC 7E, data BCF2 with stuffing on: no stuff bits
    run_pkt(8'h7E, 16'hBCF2, 1'b1);
    for (int i = 0; i < 8; i++) v8[i] = cap_line[i + 1];
    check("sync_line", 32'(v8), 32'h80);
    c = 0;
    for (int i = 1; i <= 8; i++) if (cap_sp[i] && cap_op[i] == OP_SYNC) c++;
    check("sync_cycles", 32'(c), 32'd8);
    c = 0;
    for (int i = 0; i < cap_n; i++) if (cap_sp[i]) c++;
    check("sync_total", 32'(c), 32'd8);
    check("bcf2_len", 32'(cap_n), 32'd28);
    check("bcf2_data", 32'(count_op(OP_DATA)), 32'd16);
    check("bcf2_stuff", 32'(count_op(OP_STUFF)), 32'd0);
    for (int i = 0; i < 16; i++) v16[i] = cap_line[i + 9];
    check("bcf2_line", 32'(v16), 32'hC104);

    // FFFF with stuffing on: stuff at data positions 7 and 14
    run_pkt(8'h7E, 16'hFFFF, 1'b1);
    check("ffff_len", 32'(cap_n), 32'd30);
    check("ffff_nstuff", 32'(count_op(OP_STUFF)), 32'd2);
    check("ffff_stuff7", 32'(cap_op[15]), 32'(OP_STUFF));
    check("ffff_stuff14", 32'(cap_op[22]), 32'(OP_STUFF));
    check("ffff_hold", 32'(cap_line[14]), 32'd1);
    check("ffff_tog1", 32'(cap_line[15]), 32'd0);
    check("ffff_tog2", 32'(cap_line[22]), 32'd1);
    check("ffff_eop", 32'({cap_op[27], cap_line[27], cap_line[28]}), 32'({OP_EOP, 2'b00}));
    check("ffff_end", 32'({cap_op[29], cap_line[29]}), 32'({OP_IDLE, 1'b1}));

    // FFFF with stuffing off
    run_pkt(8'h7E, 16'hFFFF, 1'b0);
    check("nost_len", 32'(cap_n), 32'd28);
    check("nost_stuff", 32'(count_op(OP_STUFF)), 32'd0);
    for (int i = 0; i < 16; i++) v16[i] = cap_line[i + 9];
    check("nost_line", 32'(v16), 32'hFFFF);
    check("nost_eop", 32'({cap_op[25], cap_op[26], cap_line[25], cap_line[26]}),
          32'({OP_EOP, OP_EOP, 2'b00}));
    check("nost_end", 32'({cap_op[27], cap_line[27]}), 32'({OP_IDLE, 1'b1}));

    // Reset mid-DATA, then back-to-back packets with SIE held
    sync_data = 8'h7E; data_in = 16'hFFFF; STUFF_OPER_tx = 1'b1; SIE = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_data", 32'(opcode), 32'(OP_DATA));
    rst = 1'b1;
    @(negedge clk);
    check("abort", 32'({opcode, encoded_dataout, SYNC_pattern}), 32'({OP_IDLE, 2'b10}));
    rst = 1'b0;
    @(negedge clk);
    check("b2b_e0a", 32'({opcode, encoded_dataout}), 32'({OP_IDLE, 1'b1}));
    @(negedge clk);
    check("b2b_sync_a", 32'(opcode), 32'(OP_SYNC));
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (opcode == OP_EOP) seen = 1'b1;
      if (seen && opcode == OP_IDLE) break;
    end
    check("b2b_ret", 32'({opcode, encoded_dataout}), 32'({OP_IDLE, 1'b1}));
    @(negedge clk);
    check("b2b_e0b", 32'({opcode, encoded_dataout}), 32'({OP_IDLE, 1'b1}));
    @(negedge clk);
    check("b2b_sync_b", 32'({opcode, SYNC_pattern}), 32'({OP_SYNC, 1'b1}));
    SIE = 1'b0;
    repeat (40) @(negedge clk);

    // Randomized traffic: inputs, SIE and occasional resets change freely
    for (int cyc = 0; cyc < 3000; cyc++) begin
      SIE           = ($urandom_range(0, 3) != 0);
      STUFF_OPER_tx = $urandom_range(0, 1);
      sync_data     = 8'($urandom);
      data_in       = ($urandom_range(0, 2) == 0) ? (16'hFFFF ^ (16'd1 << $urandom_range(0, 15)))
                                                  : 16'($urandom);
      rst           = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0; SIE = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
